// File: rtl/rx_share_arbiter.sv
// rx_share_arbiter: shares one subcomponent datapath between two 10-bit
// receive requesters (data_rx_1 / data_rx_2).
//
// A round-robin arbiter grants one requester word per cycle into a registered
// request slot toward the subcomponent. The owner of every granted word is
// pushed into a tag FIFO. In-order responses from the subcomponent pop the
// FIFO and are steered back to the owning requester one cycle later.
//
// Ports:
//   clk, rst                  clock, asynchronous active-high reset
//   enable                    gates new grants only
//   req1_valid/data/ready     requester 1 handshake (ready is combinational)
//   req2_valid/data/ready     requester 2 handshake (ready is combinational)
//   sub_valid/data/ready      request slot toward the shared subcomponent
//   sub_rsp_valid/data        in-order responses from the subcomponent
//   rsp1_valid, rsp2_valid    one-cycle response strobes per requester
//   rsp_data                  response word, shared by both strobes
//   outstanding               tag FIFO occupancy
//   err_orphan                sticky: response seen with nothing in flight
//
// OUTST must be a power of two (2..16) so the FIFO pointers wrap naturally.

module rx_share_arbiter #(
   parameter int unsigned DWIDTH = 10,
   parameter int unsigned OUTST  = 4
) (
   input  logic                     clk,
   input  logic                     rst,
   input  logic                     enable,
   input  logic                     req1_valid,
   input  logic [DWIDTH-1:0]        req1_data,
   output logic                     req1_ready,
   input  logic                     req2_valid,
   input  logic [DWIDTH-1:0]        req2_data,
   output logic                     req2_ready,
   output logic                     sub_valid,
   output logic [DWIDTH-1:0]        sub_data,
   input  logic                     sub_ready,
   input  logic                     sub_rsp_valid,
   input  logic [DWIDTH-1:0]        sub_rsp_data,
   output logic                     rsp1_valid,
   output logic                     rsp2_valid,
   output logic [DWIDTH-1:0]        rsp_data,
   output logic [$clog2(OUTST):0]   outstanding,
   output logic                     err_orphan
);

   localparam int unsigned PW = $clog2(OUTST);
   localparam int unsigned CW = PW + 1;

   // Registered state
   logic                r_sub_valid;
   logic [DWIDTH-1:0]   r_sub_data;
   logic                r_rsp1_valid;
   logic                r_rsp2_valid;
   logic [DWIDTH-1:0]   r_rsp_data;
   logic [CW-1:0]       r_count;
   logic                r_err_orphan;
   logic                r_last_req2;   // 1: requester 2 was granted last
   logic [OUTST-1:0]    r_tag;         // 0 = req1 owns the word, 1 = req2
   logic [PW-1:0]       r_wr_ptr;
   logic [PW-1:0]       r_rd_ptr;

   // Combinational decode
   logic                w_slot_free;
   logic                w_can_grant;
   logic                w_win_req2;
   logic                w_grant;
   logic                w_pop;
   logic                w_orphan;
   logic                w_head_tag;

   // Grant decision and response classification
   always_comb begin
      w_slot_free = !r_sub_valid || sub_ready;
      // Registered occupancy only: a same-cycle pop never frees room here.
      w_can_grant = enable && w_slot_free && (r_count < CW'(OUTST));
      // Requester 2 wins when alone, or when both are valid and req1 went last.
      w_win_req2  = req2_valid && (!req1_valid || !r_last_req2);
      w_grant     = w_can_grant && (req1_valid || req2_valid);
      w_pop       = sub_rsp_valid && (r_count != '0);
      w_orphan    = sub_rsp_valid && (r_count == '0);
      w_head_tag  = r_tag[r_rd_ptr];
   end

   assign req1_ready = w_grant && !w_win_req2;
   assign req2_ready = w_grant &&  w_win_req2;

   // Request slot toward the subcomponent; holds until accepted
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         r_sub_valid <= 1'b0;
         r_sub_data  <= '0;
      end else if (w_grant) begin
         r_sub_valid <= 1'b1;
         r_sub_data  <= w_win_req2 ? req2_data : req1_data;
      end else if (sub_ready) begin
         r_sub_valid <= 1'b0;
      end
   end

   // Round-robin pointer moves only on a grant
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         r_last_req2 <= 1'b1;
      end else if (w_grant) begin
         r_last_req2 <= w_win_req2;
      end
   end

   // Tag FIFO storage and pointers
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         r_tag    <= '0;
         r_wr_ptr <= '0;
         r_rd_ptr <= '0;
      end else begin
         if (w_grant) begin
            r_tag[r_wr_ptr] <= w_win_req2;
            r_wr_ptr        <= r_wr_ptr + PW'(1);
         end
         if (w_pop) begin
            r_rd_ptr <= r_rd_ptr + PW'(1);
         end
      end
   end

   // Occupancy: simultaneous push and pop leave it unchanged
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         r_count <= '0;
      end else begin
         case ({w_grant, w_pop})
            2'b10:   r_count <= r_count + CW'(1);
            2'b01:   r_count <= r_count - CW'(1);
            default: r_count <= r_count;
         endcase
      end
   end

   // Response steering; rsp_data holds between strobes
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         r_rsp1_valid <= 1'b0;
         r_rsp2_valid <= 1'b0;
         r_rsp_data   <= '0;
      end else begin
         r_rsp1_valid <= w_pop && !w_head_tag;
         r_rsp2_valid <= w_pop &&  w_head_tag;
         if (w_pop) begin
            r_rsp_data <= sub_rsp_data;
         end
      end
   end

   // Sticky orphan-response flag
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         r_err_orphan <= 1'b0;
      end else if (w_orphan) begin
         r_err_orphan <= 1'b1;
      end
   end

   assign sub_valid   = r_sub_valid;
   assign sub_data    = r_sub_data;
   assign rsp1_valid  = r_rsp1_valid;
   assign rsp2_valid  = r_rsp2_valid;
   assign rsp_data    = r_rsp_data;
   assign outstanding = r_count;
   assign err_orphan  = r_err_orphan;

endmodule

// File: tb/tb_rx_share_arbiter.sv
// Testbench for rx_share_arbiter: directed scenarios plus random traffic,
// checked against a queue-based reference model with a decoupled monitor.

module tb_rx_share_arbiter;

   localparam int unsigned DW    = 10;
   localparam int unsigned OUTST = 4;

   typedef struct packed {
      logic          owner;   // 0 = req1, 1 = req2
      logic [DW-1:0] data;
   } rsp_t;

   logic          clk = 1'b0;
   logic          rst;
   logic          enable;
   logic          req1_valid, req2_valid;
   logic [DW-1:0] req1_data, req2_data;
   logic          req1_ready, req2_ready;
   logic          sub_valid;
   logic [DW-1:0] sub_data;
   logic          sub_ready;
   logic          sub_rsp_valid;
   logic [DW-1:0] sub_rsp_data;
   logic          rsp1_valid, rsp2_valid;
   logic [DW-1:0] rsp_data;
   logic [2:0]    outstanding;
   logic          err_orphan;

   rx_share_arbiter #(.DWIDTH(DW), .OUTST(OUTST)) dut (
      .clk(clk), .rst(rst), .enable(enable),
      .req1_valid(req1_valid), .req1_data(req1_data), .req1_ready(req1_ready),
      .req2_valid(req2_valid), .req2_data(req2_data), .req2_ready(req2_ready),
      .sub_valid(sub_valid), .sub_data(sub_data), .sub_ready(sub_ready),
      .sub_rsp_valid(sub_rsp_valid), .sub_rsp_data(sub_rsp_data),
      .rsp1_valid(rsp1_valid), .rsp2_valid(rsp2_valid), .rsp_data(rsp_data),
      .outstanding(outstanding), .err_orphan(err_orphan)
   );

   always #5 clk = ~clk;

   int total = 0;
   int bad   = 0;

   // Reference model state
   bit            own_q[$];    // owners of words in flight, oldest first
   logic [DW-1:0] sub_q[$];    // granted words awaiting subcomponent acceptance
   rsp_t          rsp_q[$];    // responses expected at the requesters
   bit            m_last;      // 1: requester 2 was granted last
   bit            m_subv;
   logic [DW-1:0] m_sdata;
   bit            m_r1, m_r2;
   logic [DW-1:0] m_rdata;
   bit            m_orph;
   bit            g1, g2;      // grants predicted in the most recent step

   function automatic void chk(string name, int act, int exp);
      total++;
      if (act != exp) begin
         bad++;
         $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
      end
   endfunction

   task automatic model_clear();
      own_q.delete(); sub_q.delete(); rsp_q.delete();
      m_last = 1'b1; m_subv = 1'b0; m_sdata = '0;
      m_r1 = 1'b0; m_r2 = 1'b0; m_rdata = '0; m_orph = 1'b0;
   endtask

   task automatic set_in(bit v1, logic [DW-1:0] d1, bit v2, logic [DW-1:0] d2,
                         bit sr, bit rv, logic [DW-1:0] rd, bit en);
      req1_valid = v1; req1_data = d1; req2_valid = v2; req2_data = d2;
      sub_ready = sr; sub_rsp_valid = rv; sub_rsp_data = rd; enable = en;
   endtask

   // One clock cycle: check registered outputs and readys, then advance the model
   task automatic step();
      bit  cg, win2, o;
      @(negedge clk);
      chk("sub_valid",   32'(sub_valid),   32'(m_subv));
      chk("sub_data",    32'(sub_data),    32'(m_sdata));
      chk("outstanding", 32'(outstanding), own_q.size());
      chk("err_orphan",  32'(err_orphan),  32'(m_orph));
      chk("rsp1_valid",  32'(rsp1_valid),  32'(m_r1));
      chk("rsp2_valid",  32'(rsp2_valid),  32'(m_r2));
      chk("rsp_data",    32'(rsp_data),    32'(m_rdata));
      cg   = enable && (!m_subv || sub_ready) && (own_q.size() < OUTST);
      win2 = (req1_valid && req2_valid) ? !m_last : req2_valid;
      g1   = cg && req1_valid && !win2;
      g2   = cg && req2_valid &&  win2;
      chk("req1_ready", 32'(req1_ready), 32'(g1));
      chk("req2_ready", 32'(req2_ready), 32'(g2));
      m_r1 = 1'b0; m_r2 = 1'b0;
      if (sub_rsp_valid) begin
         if (own_q.size() > 0) begin
            o = own_q.pop_front();
            rsp_q.push_back('{owner: o, data: sub_rsp_data});
            m_rdata = sub_rsp_data;
            m_r1 = !o; m_r2 = o;
         end else begin
            m_orph = 1'b1;
         end
      end
      if (g1 || g2) begin
         own_q.push_back(g2);
         m_sdata = g2 ? req2_data : req1_data;
         sub_q.push_back(m_sdata);
         m_last = g2;
         m_subv = 1'b1;
      end else if (sub_ready) begin
         m_subv = 1'b0;
      end
      @(posedge clk);
      #1;
   endtask

   // Return every word in flight and empty the request slot
   task automatic drain();
      for (int k = 0; k < 40 && (own_q.size() > 0 || m_subv); k++) begin
         set_in(0, '0, 0, '0, 1, own_q.size() > 0, DW'($urandom), 1);
         step();
      end
      set_in(0, '0, 0, '0, 1, 0, '0, 1);
      step();
   endtask

   task automatic do_reset();
      #2;
      rst = 1'b1;
      set_in(0, '0, 0, '0, 0, 0, '0, 1);
      #1;
      chk("rst_sub_valid",   32'(sub_valid),   0);
      chk("rst_sub_data",    32'(sub_data),    0);
      chk("rst_rsp1",        32'(rsp1_valid),  0);
      chk("rst_rsp2",        32'(rsp2_valid),  0);
      chk("rst_rsp_data",    32'(rsp_data),    0);
      chk("rst_outstanding", 32'(outstanding), 0);
      chk("rst_err_orphan",  32'(err_orphan),  0);
      model_clear();
      @(negedge clk);
      @(negedge clk);
      rst = 1'b0;
      @(posedge clk);
      #1;
   endtask

   // Monitor: scoreboard for accepted sub words and routed responses
   always @(negedge clk) begin
      if (!rst) begin
         if (sub_valid && sub_ready) begin
            if (sub_q.size() == 0) begin
               chk("sub_accept_unexpected", 1, 0);
            end else begin
               chk("sb_sub_word", 32'(sub_data), 32'(sub_q.pop_front()));
            end
         end
         if (rsp1_valid || rsp2_valid) begin
            chk("sb_rsp_onehot", 32'(rsp1_valid && rsp2_valid), 0);
            if (rsp_q.size() == 0) begin
               chk("sb_rsp_unexpected", 1, 0);
            end else begin
               rsp_t e;
               e = rsp_q.pop_front();
               chk("sb_rsp_owner", 32'(rsp2_valid), 32'(e.owner));
               chk("sb_rsp_word",  32'(rsp_data),   32'(e.data));
            end
         end
      end
   end

   initial begin
      logic [DW-1:0] d1, d2;
      rst = 1'b1;
      set_in(0, '0, 0, '0, 0, 0, '0, 1);
      model_clear();
      @(negedge clk);
      @(negedge clk);
      chk("init_sub_valid",   32'(sub_valid),   0);
      chk("init_outstanding", 32'(outstanding), 0);
      chk("init_err_orphan",  32'(err_orphan),  0);
      chk("init_rsp_data",    32'(rsp_data),    0);
      rst = 1'b0;
      @(posedge clk);
      #1;

      // Contention: alternate grants starting with req1
      d1 = 10'h001; d2 = 10'h101;
      for (int i = 0; i < 12; i++) begin
         set_in(1, d1, 1, d2, 1, own_q.size() > 0, DW'($urandom), 1);
         if (i == 0) begin
            #1;
            chk("contend_first_req1", 32'(req1_ready), 1);
            chk("contend_first_req2", 32'(req2_ready), 0);
         end
         step();
         if (g1) d1 = d1 + 10'd1;
         if (g2) d2 = d2 + 10'd1;
      end
      drain();

      // Single requester with response two cycles later
      set_in(1, 10'h155, 0, '0, 1, 0, '0, 1);
      step();
      set_in(0, '0, 0, '0, 1, 0, '0, 1);
      #1;
      chk("single_sub_valid", 32'(sub_valid), 1);
      chk("single_sub_data",  32'(sub_data),  32'h155);
      step();
      set_in(0, '0, 0, '0, 1, 1, 10'h2AA, 1);
      step();
      set_in(0, '0, 0, '0, 1, 0, '0, 1);
      #1;
      chk("single_rsp1", 32'(rsp1_valid), 1);
      chk("single_rsp2", 32'(rsp2_valid), 0);
      chk("single_data", 32'(rsp_data),   32'h2AA);
      step();
      drain();

      // Fill the tag FIFO, then free one entry
      for (int i = 0; i < 6; i++) begin
         set_in(1, DW'(10'h040 + i), 0, '0, 1, 0, '0, 1);
         step();
      end
      set_in(1, 10'h046, 0, '0, 1, 0, '0, 1);
      #1;
      chk("full_outstanding", 32'(outstanding), 4);
      chk("full_ready1",      32'(req1_ready),  0);
      set_in(1, 10'h046, 0, '0, 1, 1, 10'h111, 1);
      #1;
      chk("full_pop_no_grant", 32'(req1_ready), 0);
      step();
      set_in(1, 10'h046, 0, '0, 1, 0, '0, 1);
      #1;
      chk("full_after_pop_cnt",   32'(outstanding), 3);
      chk("full_after_pop_grant", 32'(req1_ready),  1);
      step();
      drain();

      // Stall hold: slot stays stable while sub_ready is low
      set_in(1, 10'h0A0, 0, '0, 1, 0, '0, 1);
      step();
      for (int i = 0; i < 5; i++) begin
         set_in(1, 10'h0A1, 0, '0, 0, 0, '0, 1);
         step();
      end
      #1;
      chk("stall_data",  32'(sub_data),   32'h0A0);
      chk("stall_ready", 32'(req1_ready), 0);
      set_in(1, 10'h0A1, 0, '0, 1, 0, '0, 1);
      step();
      set_in(0, '0, 0, '0, 1, 0, '0, 1);
      #1;
      chk("stall_next_word", 32'(sub_data), 32'h0A1);
      step();
      drain();

      // Orphan response
      set_in(0, '0, 0, '0, 1, 1, 10'h3FF, 1);
      step();
      set_in(0, '0, 0, '0, 1, 0, '0, 1);
      #1;
      chk("orphan_flag", 32'(err_orphan), 1);
      chk("orphan_no_rsp", 32'(rsp1_valid || rsp2_valid), 0);
      step();

      // Enable low with two words in flight
      set_in(1, 10'h0C1, 0, '0, 1, 0, '0, 1);
      step();
      set_in(0, '0, 1, 10'h0C2, 1, 0, '0, 1);
      step();
      set_in(1, 10'h0C3, 1, 10'h0C4, 1, 0, '0, 0);
      #1;
      chk("en_low_ready1", 32'(req1_ready), 0);
      chk("en_low_ready2", 32'(req2_ready), 0);
      step();
      set_in(1, 10'h0C3, 1, 10'h0C4, 1, 1, 10'h2C1, 0);
      step();
      set_in(1, 10'h0C3, 1, 10'h0C4, 1, 1, 10'h2C2, 0);
      step();
      set_in(0, '0, 0, '0, 1, 0, '0, 0);
      step();
      step();

      // Reset with three words in flight
      for (int i = 0; i < 3; i++) begin
         set_in(1, DW'(10'h0E0 + i), 0, '0, 1, 0, '0, 1);
         step();
      end
      do_reset();
      set_in(1, 10'h0F1, 1, 10'h0F2, 1, 1, 10'h0F3, 1);
      #1;
      chk("post_rst_req1", 32'(req1_ready), 1);
      chk("post_rst_req2", 32'(req2_ready), 0);
      step();
      drain();

      // Random traffic
      for (int i = 0; i < 400; i++) begin
         bit rv;
         rv = (own_q.size() > 0) ? ($urandom_range(0, 2) != 0) : ($urandom_range(0, 30) == 0);
         set_in(1'($urandom), DW'($urandom), 1'($urandom), DW'($urandom),
                $urandom_range(0, 3) != 0, rv, DW'($urandom), $urandom_range(0, 7) != 0);
         step();
      end
      drain();
      step();
      chk("end_rsp_queue_empty", rsp_q.size(), 0);
      chk("end_sub_queue_empty", sub_q.size(), 0);

      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end

   // Watchdog
   initial begin
      #400000;
      $display("FAIL watchdog: simulation did not finish, got timeout expected finish");
      $fatal(1);
   end

endmodule
